// File: rtl/reorder_buffer_param_if.sv
// Port bundle for reorder_buffer_param: dispatch, CDB, operand-read, retire and status signals.
// slave is the ROB side, master the surrounding pipeline (or testbench).
interface reorder_buffer_param_if #(
   parameter int IDX_W  = 5,
   parameter int DATA_W = 64
);
   // Handshakes: a dispatch request (instN_valid_in) is taken only in a cycle where
   // instN_grant_out is high; CDB valids are single-cycle broadcasts with no back-pressure;
   // retN_valid_out commits unconditionally, the consumer cannot stall it.
   logic                  inst1_valid_in;
   logic [4:0]            inst1_dest_in;
   logic                  inst2_valid_in;
   logic [4:0]            inst2_dest_in;
   logic                  inst1_grant_out;
   logic                  inst2_grant_out;
   logic [IDX_W-1:0]      inst1_tag_out;
   logic [IDX_W-1:0]      inst2_tag_out;

   logic                  cdb1_valid_in;
   logic [IDX_W-1:0]      cdb1_tag_in;
   logic [DATA_W-1:0]     cdb1_value_in;
   logic                  cdb1_mispredicted_in;
   logic                  cdb2_valid_in;
   logic [IDX_W-1:0]      cdb2_tag_in;
   logic [DATA_W-1:0]     cdb2_value_in;
   logic                  cdb2_mispredicted_in;

   logic [4*IDX_W-1:0]    rd_tag_in;
   logic [4*DATA_W-1:0]   rd_value_out;
   logic [3:0]            rd_ready_out;

   logic                  ret1_valid_out;
   logic [4:0]            ret1_dest_out;
   logic [DATA_W-1:0]     ret1_value_out;
   logic                  ret2_valid_out;
   logic [4:0]            ret2_dest_out;
   logic [DATA_W-1:0]     ret2_value_out;

   logic                  mispredict_out;
   logic                  rob_full;
   logic                  rob_empty;
   logic [IDX_W:0]        count_out;
   logic [IDX_W-1:0]      dbg_head;
   logic [IDX_W-1:0]      dbg_tail;

   modport slave (
      input  inst1_valid_in, inst1_dest_in, inst2_valid_in, inst2_dest_in,
      output inst1_grant_out, inst2_grant_out, inst1_tag_out, inst2_tag_out,
      input  cdb1_valid_in, cdb1_tag_in, cdb1_value_in, cdb1_mispredicted_in,
      input  cdb2_valid_in, cdb2_tag_in, cdb2_value_in, cdb2_mispredicted_in,
      input  rd_tag_in,
      output rd_value_out, rd_ready_out,
      output ret1_valid_out, ret1_dest_out, ret1_value_out,
      output ret2_valid_out, ret2_dest_out, ret2_value_out,
      output mispredict_out, rob_full, rob_empty, count_out, dbg_head, dbg_tail
   );

   modport master (
      output inst1_valid_in, inst1_dest_in, inst2_valid_in, inst2_dest_in,
      input  inst1_grant_out, inst2_grant_out, inst1_tag_out, inst2_tag_out,
      output cdb1_valid_in, cdb1_tag_in, cdb1_value_in, cdb1_mispredicted_in,
      output cdb2_valid_in, cdb2_tag_in, cdb2_value_in, cdb2_mispredicted_in,
      output rd_tag_in,
      input  rd_value_out, rd_ready_out,
      input  ret1_valid_out, ret1_dest_out, ret1_value_out,
      input  ret2_valid_out, ret2_dest_out, ret2_value_out,
      input  mispredict_out, rob_full, rob_empty, count_out, dbg_head, dbg_tail
   );
endinterface

// File: rtl/reorder_buffer_param.sv
// 2-wide reorder buffer: in-order dispatch, out-of-order CDB completion, in-order retire, mispredict flush.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB results to the operand read ports.
module reorder_buffer_param #(
   parameter int DEPTH  = 32,
   parameter int IDX_W  = 5,
   parameter int DATA_W = 64
) (
   input logic                    clock,
   input logic                    reset,
   reorder_buffer_param_if.slave  rob
);
   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_INUSE    = 2'd1,
      ST_COMPLETE = 2'd2
   } entry_state_e;

   localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] CNT_LIM2 = (IDX_W+1)'(DEPTH - 2);

   entry_state_e      state_q [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [4:0]        dest_q  [DEPTH];
   logic              misp_q  [DEPTH];

   logic [IDX_W-1:0]  head_q, tail_q, head1, tail1;
   logic [IDX_W:0]    count_q;
   logic              g1, g2, ret1, ret2, flush;
   logic [4:0]        slot1_dest;
   logic [IDX_W-1:0]  rd_idx;

   // Grants use the start-of-cycle count, so entries retiring this cycle are not reallocated.
   always_comb begin
      head1      = head_q + IDX_W'(1);
      tail1      = tail_q + IDX_W'(1);
      ret1       = (state_q[head_q] == ST_COMPLETE);
      ret2       = ret1 && (state_q[head1] == ST_COMPLETE) && !misp_q[head_q];
      flush      = ret1 && misp_q[head_q];
      g1         = !flush && (rob.inst1_valid_in || rob.inst2_valid_in) && (count_q < CNT_FULL);
      g2         = !flush && rob.inst1_valid_in && rob.inst2_valid_in && (count_q <= CNT_LIM2);
      slot1_dest = rob.inst1_valid_in ? rob.inst1_dest_in : rob.inst2_dest_in;
   end

   assign rob.inst1_grant_out = g1;
   assign rob.inst2_grant_out = g2;
   assign rob.inst1_tag_out   = g1 ? tail_q : '0;
   assign rob.inst2_tag_out   = g2 ? tail1 : '0;
   assign rob.ret1_valid_out  = ret1;
   assign rob.ret1_dest_out   = ret1 ? dest_q[head_q] : '0;
   assign rob.ret1_value_out  = ret1 ? value_q[head_q] : '0;
   assign rob.ret2_valid_out  = ret2;
   assign rob.ret2_dest_out   = ret2 ? dest_q[head1] : '0;
   assign rob.ret2_value_out  = ret2 ? value_q[head1] : '0;
   assign rob.mispredict_out  = flush;
   assign rob.rob_full        = (count_q == CNT_FULL);
   assign rob.rob_empty       = (count_q == '0);
   assign rob.count_out       = count_q;
   assign rob.dbg_head        = head_q;
   assign rob.dbg_tail        = tail_q;

   always_comb begin
      rob.rd_value_out = '0;
      rob.rd_ready_out = '0;
      rd_idx           = '0;
      for (int k = 0; k < 4; k++) begin
         rd_idx = rob.rd_tag_in[k*IDX_W +: IDX_W];
         if (state_q[rd_idx] == ST_COMPLETE) begin
            rob.rd_ready_out[k]                  = 1'b1;
            rob.rd_value_out[k*DATA_W +: DATA_W] = value_q[rd_idx];
         end
`ifdef ROB_CDB_BYPASS_EN
         // Forward only to entries still waiting; cdb1 takes priority over cdb2.
         if (state_q[rd_idx] == ST_INUSE) begin
            if (rob.cdb1_valid_in && (rob.cdb1_tag_in == rd_idx)) begin
               rob.rd_ready_out[k]                  = 1'b1;
               rob.rd_value_out[k*DATA_W +: DATA_W] = rob.cdb1_value_in;
            end else if (rob.cdb2_valid_in && (rob.cdb2_tag_in == rd_idx)) begin
               rob.rd_ready_out[k]                  = 1'b1;
               rob.rd_value_out[k*DATA_W +: DATA_W] = rob.cdb2_value_in;
            end
         end
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= ST_EMPTY;
            value_q[i] <= '0;
            dest_q[i]  <= '0;
            misp_q[i]  <= 1'b0;
         end
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            state_q[i] <= ST_EMPTY;
         end
      end else begin
         // Retire, dispatch and CDB targets are disjoint by state (COMPLETE/EMPTY/INUSE).
         if (ret1) state_q[head_q] <= ST_EMPTY;
         if (ret2) state_q[head1]  <= ST_EMPTY;
         if (g1) begin
            state_q[tail_q] <= ST_INUSE;
            dest_q[tail_q]  <= slot1_dest;
            misp_q[tail_q]  <= 1'b0;
         end
         if (g2) begin
            state_q[tail1] <= ST_INUSE;
            dest_q[tail1]  <= rob.inst2_dest_in;
            misp_q[tail1]  <= 1'b0;
         end
         if (rob.cdb2_valid_in && (state_q[rob.cdb2_tag_in] == ST_INUSE)) begin
            state_q[rob.cdb2_tag_in] <= ST_COMPLETE;
            value_q[rob.cdb2_tag_in] <= rob.cdb2_value_in;
            misp_q[rob.cdb2_tag_in]  <= rob.cdb2_mispredicted_in;
         end
         // Written after cdb2 so cdb1 wins when both target the same entry.
         if (rob.cdb1_valid_in && (state_q[rob.cdb1_tag_in] == ST_INUSE)) begin
            state_q[rob.cdb1_tag_in] <= ST_COMPLETE;
            value_q[rob.cdb1_tag_in] <= rob.cdb1_value_in;
            misp_q[rob.cdb1_tag_in]  <= rob.cdb1_mispredicted_in;
         end
         head_q  <= head_q + IDX_W'(ret1) + IDX_W'(ret2);
         tail_q  <= tail_q + IDX_W'(g1) + IDX_W'(g2);
         count_q <= count_q + (IDX_W+1)'(g1) + (IDX_W+1)'(g2)
                            - (IDX_W+1)'(ret1) - (IDX_W+1)'(ret2);
      end
   end
endmodule

// File: tb/tb_reorder_buffer_param.sv
// Self-checking bench for reorder_buffer_param: retire scoreboard plus per-scenario inline checks.
// Build with or without ROB_CDB_BYPASS_EN; bypass expectations follow the macro.
module tb_reorder_buffer_param;
   localparam int DEPTH  = 32;
   localparam int IDX_W  = 5;
   localparam int DATA_W = 64;
   localparam int SB_W   = 5 + DATA_W;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   reorder_buffer_param_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) rif ();

   reorder_buffer_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
      .clock (clock),
      .reset (reset),
      .rob   (rif.slave)
   );

   int total = 0;
   int bad   = 0;
   logic [SB_W-1:0] exp_q[$];
   logic [SB_W-1:0] mon_exp;

   // Retire scoreboard: every committed slot must match the next expected {dest, value}.
   always @(negedge clock) begin
      if (!reset) begin
         if (rif.ret1_valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL ret1_unexpected got=%0h_%0h exp=none", rif.ret1_dest_out, rif.ret1_value_out);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({rif.ret1_dest_out, rif.ret1_value_out} !== mon_exp) begin
                  bad++;
                  $display("FAIL ret1_data got=%0h_%0h exp=%0h_%0h", rif.ret1_dest_out, rif.ret1_value_out,
                           mon_exp[SB_W-1:DATA_W], mon_exp[DATA_W-1:0]);
               end
            end
         end
         if (rif.ret2_valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL ret2_unexpected got=%0h_%0h exp=none", rif.ret2_dest_out, rif.ret2_value_out);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({rif.ret2_dest_out, rif.ret2_value_out} !== mon_exp) begin
                  bad++;
                  $display("FAIL ret2_data got=%0h_%0h exp=%0h_%0h", rif.ret2_dest_out, rif.ret2_value_out,
                           mon_exp[SB_W-1:DATA_W], mon_exp[DATA_W-1:0]);
               end
            end
         end
      end
   end

   task automatic clear_inputs();
      rif.inst1_valid_in       = 1'b0;
      rif.inst1_dest_in        = '0;
      rif.inst2_valid_in       = 1'b0;
      rif.inst2_dest_in        = '0;
      rif.cdb1_valid_in        = 1'b0;
      rif.cdb1_tag_in          = '0;
      rif.cdb1_value_in        = '0;
      rif.cdb1_mispredicted_in = 1'b0;
      rif.cdb2_valid_in        = 1'b0;
      rif.cdb2_tag_in          = '0;
      rif.cdb2_value_in        = '0;
      rif.cdb2_mispredicted_in = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      rif.rd_tag_in = '0;
      exp_q.delete();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      rif.rd_tag_in = '0;
      #2;
      total++;
      if (rif.count_out !== '0 || rif.rob_empty !== 1'b1 || rif.rob_full !== 1'b0) begin
         bad++;
         $display("FAIL reset_status got=%0d/%b/%b exp=0/1/0", rif.count_out, rif.rob_empty, rif.rob_full);
      end
      total++;
      if ({rif.inst1_grant_out, rif.inst2_grant_out, rif.ret1_valid_out, rif.ret2_valid_out,
           rif.mispredict_out, rif.rd_ready_out} !== 9'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b%b%b%b%b%b exp=0", rif.inst1_grant_out, rif.inst2_grant_out,
                  rif.ret1_valid_out, rif.ret2_valid_out, rif.mispredict_out, rif.rd_ready_out);
      end
      total++;
      if ({rif.inst1_tag_out, rif.inst2_tag_out, rif.dbg_head, rif.dbg_tail} !== '0 || rif.rd_value_out !== '0) begin
         bad++;
         $display("FAIL reset_data got=%0h/%0h/%0h/%0h exp=0", rif.inst1_tag_out, rif.inst2_tag_out,
                  rif.dbg_head, rif.dbg_tail);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      // Fill a little, then assert reset between clock edges.
      rif.inst1_valid_in = 1'b1;
      rif.inst2_valid_in = 1'b1;
      step();
      step();
      clear_inputs();
      total++;
      if (rif.count_out !== 6'd4) begin
         bad++;
         $display("FAIL pre_async_count got=%0d exp=4", rif.count_out);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (rif.count_out !== '0 || rif.rob_empty !== 1'b1 || rif.dbg_tail !== '0) begin
         bad++;
         $display("FAIL async_reset got=%0d/%b/%0d exp=0/1/0", rif.count_out, rif.rob_empty, rif.dbg_tail);
      end
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_fill();
      logic [4:0]       d0;
      logic [IDX_W-1:0] t;
      do_reset();
      d0 = '0;
      for (int i = 0; i < 16; i++) begin
         rif.inst1_valid_in = 1'b1;
         rif.inst2_valid_in = 1'b1;
         rif.inst1_dest_in  = 5'($urandom_range(0, 31));
         rif.inst2_dest_in  = 5'($urandom_range(0, 31));
         if (i == 0) d0 = rif.inst1_dest_in;
         t = IDX_W'(2 * i);
         @(negedge clock);
         total++;
         if ({rif.inst1_grant_out, rif.inst2_grant_out} !== 2'b11 || rif.inst1_tag_out !== t ||
             rif.inst2_tag_out !== t + IDX_W'(1)) begin
            bad++;
            $display("FAIL fill_grant i=%0d got=%b%b/%0d/%0d exp=11/%0d/%0d", i, rif.inst1_grant_out,
                     rif.inst2_grant_out, rif.inst1_tag_out, rif.inst2_tag_out, t, t + IDX_W'(1));
         end
         step();
      end
      @(negedge clock);
      total++;
      if (rif.count_out !== 6'd32 || rif.rob_full !== 1'b1 || rif.rob_empty !== 1'b0) begin
         bad++;
         $display("FAIL fill_full got=%0d/%b/%b exp=32/1/0", rif.count_out, rif.rob_full, rif.rob_empty);
      end
      total++;
      if ({rif.inst1_grant_out, rif.inst2_grant_out} !== 2'b00) begin
         bad++;
         $display("FAIL full_no_grant got=%b%b exp=00", rif.inst1_grant_out, rif.inst2_grant_out);
      end
      step();
      rif.cdb1_valid_in = 1'b1;
      rif.cdb1_tag_in   = '0;
      rif.cdb1_value_in = 64'h5;
      exp_q.push_back({d0, 64'h5});
      step();
      rif.cdb1_valid_in = 1'b0;
      @(negedge clock);
      total++;
      if (rif.ret1_valid_out !== 1'b1 || rif.inst1_grant_out !== 1'b0 || rif.count_out !== 6'd32) begin
         bad++;
         $display("FAIL full_retire_no_dispatch got=%b/%b/%0d exp=1/0/32", rif.ret1_valid_out,
                  rif.inst1_grant_out, rif.count_out);
      end
      step();
      @(negedge clock);
      total++;
      if (rif.count_out !== 6'd31 || rif.inst1_grant_out !== 1'b1 || rif.inst2_grant_out !== 1'b0) begin
         bad++;
         $display("FAIL one_free got=%0d/%b/%b exp=31/1/0", rif.count_out, rif.inst1_grant_out,
                  rif.inst2_grant_out);
      end
      clear_inputs();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL fill_sb_left got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_lone_inst2();
      do_reset();
      rif.inst2_valid_in = 1'b1;
      rif.inst2_dest_in  = 5'd7;
      @(negedge clock);
      total++;
      if ({rif.inst1_grant_out, rif.inst2_grant_out} !== 2'b10 || rif.inst1_tag_out !== '0) begin
         bad++;
         $display("FAIL lone_inst2_grant got=%b%b/%0d exp=10/0", rif.inst1_grant_out, rif.inst2_grant_out,
                  rif.inst1_tag_out);
      end
      step();
      clear_inputs();
      @(negedge clock);
      total++;
      if (rif.count_out !== 6'd1) begin
         bad++;
         $display("FAIL lone_inst2_count got=%0d exp=1", rif.count_out);
      end
      rif.cdb1_valid_in = 1'b1;
      rif.cdb1_tag_in   = '0;
      rif.cdb1_value_in = 64'h33;
      exp_q.push_back({5'd7, 64'h33});
      step();
      clear_inputs();
      @(negedge clock);
      total++;
      if (rif.ret1_valid_out !== 1'b1 || rif.ret1_dest_out !== 5'd7) begin
         bad++;
         $display("FAIL lone_inst2_dest got=%b/%0d exp=1/7", rif.ret1_valid_out, rif.ret1_dest_out);
      end
      step();
      @(negedge clock);
      total++;
      if (rif.rob_empty !== 1'b1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL lone_inst2_drain got=%b/%0d exp=1/0", rif.rob_empty, exp_q.size());
      end
   endtask

   task automatic test_ooo_complete();
      do_reset();
      rif.inst1_valid_in = 1'b1;
      rif.inst1_dest_in  = 5'd3;
      rif.inst2_valid_in = 1'b1;
      rif.inst2_dest_in  = 5'd4;
      exp_q.push_back({5'd3, 64'h11});
      exp_q.push_back({5'd4, 64'h22});
      step();
      clear_inputs();
      rif.cdb2_valid_in = 1'b1;
      rif.cdb2_tag_in   = 5'd1;
      rif.cdb2_value_in = 64'h22;
      @(negedge clock);
      total++;
      if (rif.ret1_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL ooo_early_ret_a got=%b exp=0", rif.ret1_valid_out);
      end
      step();
      clear_inputs();
      rif.cdb1_valid_in = 1'b1;
      rif.cdb1_tag_in   = '0;
      rif.cdb1_value_in = 64'h11;
      rif.rd_tag_in[1*IDX_W +: IDX_W] = 5'd1;
      @(negedge clock);
      total++;
      if (rif.ret1_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL ooo_early_ret_b got=%b exp=0", rif.ret1_valid_out);
      end
      total++;
      if (rif.rd_ready_out[1] !== 1'b1 || rif.rd_value_out[1*DATA_W +: DATA_W] !== 64'h22) begin
         bad++;
         $display("FAIL ooo_read_tag1 got=%b/%0h exp=1/22", rif.rd_ready_out[1],
                  rif.rd_value_out[1*DATA_W +: DATA_W]);
      end
      step();
      clear_inputs();
      @(negedge clock);
      total++;
      if ({rif.ret1_valid_out, rif.ret2_valid_out} !== 2'b11) begin
         bad++;
         $display("FAIL ooo_dual_retire got=%b%b exp=11", rif.ret1_valid_out, rif.ret2_valid_out);
      end
      step();
      @(negedge clock);
      total++;
      if (rif.rob_empty !== 1'b1 || rif.count_out !== '0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL ooo_drain got=%b/%0d/%0d exp=1/0/0", rif.rob_empty, rif.count_out, exp_q.size());
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      rif.inst1_valid_in = 1'b1;
      rif.inst1_dest_in  = 5'd1;
      rif.inst2_valid_in = 1'b1;
      rif.inst2_dest_in  = 5'd2;
      step();
      rif.inst1_dest_in = 5'd3;
      rif.inst2_dest_in = 5'd4;
      step();
      clear_inputs();
      @(negedge clock);
      total++;
      if (rif.count_out !== 6'd4) begin
         bad++;
         $display("FAIL misp_setup_count got=%0d exp=4", rif.count_out);
      end
      rif.cdb1_valid_in        = 1'b1;
      rif.cdb1_tag_in          = '0;
      rif.cdb1_value_in        = 64'h99;
      rif.cdb1_mispredicted_in = 1'b1;
      rif.cdb2_valid_in        = 1'b1;
      rif.cdb2_tag_in          = 5'd1;
      rif.cdb2_value_in        = 64'h77;
      exp_q.push_back({5'd1, 64'h99});
      step();
      clear_inputs();
      rif.inst1_valid_in = 1'b1;
      rif.inst1_dest_in  = 5'd9;
      rif.cdb1_valid_in  = 1'b1;
      rif.cdb1_tag_in    = 5'd2;
      rif.cdb1_value_in  = 64'h55;
      @(negedge clock);
      total++;
      if ({rif.ret1_valid_out, rif.ret2_valid_out, rif.mispredict_out, rif.inst1_grant_out} !== 4'b1010) begin
         bad++;
         $display("FAIL misp_flush_cycle got=%b%b%b%b exp=1010", rif.ret1_valid_out, rif.ret2_valid_out,
                  rif.mispredict_out, rif.inst1_grant_out);
      end
      step();
      clear_inputs();
      rif.rd_tag_in[0 +: IDX_W] = 5'd2;
      @(negedge clock);
      total++;
      if (rif.count_out !== '0 || rif.rob_empty !== 1'b1 || rif.dbg_head !== '0 || rif.dbg_tail !== '0) begin
         bad++;
         $display("FAIL misp_after_flush got=%0d/%b/%0d/%0d exp=0/1/0/0", rif.count_out, rif.rob_empty,
                  rif.dbg_head, rif.dbg_tail);
      end
      total++;
      if (rif.rd_ready_out[0] !== 1'b0 || rif.ret1_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL misp_discarded got=%b/%b exp=0/0", rif.rd_ready_out[0], rif.ret1_valid_out);
      end
      rif.inst1_valid_in = 1'b1;
      #1;
      total++;
      if (rif.inst1_grant_out !== 1'b1 || rif.inst1_tag_out !== '0) begin
         bad++;
         $display("FAIL misp_restart_tag got=%b/%0d exp=1/0", rif.inst1_grant_out, rif.inst1_tag_out);
      end
      clear_inputs();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL misp_sb_left got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      logic [IDX_W-1:0] tag;
      logic [IDX_W-1:0] prev_tag;
      logic [4:0]       d;
      do_reset();
      tag      = '0;
      prev_tag = '0;
      for (int i = 0; i < 42; i++) begin
         clear_inputs();
         if (i < 40) begin
            d = 5'((i % 31) + 1);
            rif.inst1_valid_in = 1'b1;
            rif.inst1_dest_in  = d;
            exp_q.push_back({d, 64'h1000 + 64'(i)});
         end
         if (i >= 1 && i <= 40) begin
            rif.cdb1_valid_in = 1'b1;
            rif.cdb1_tag_in   = prev_tag;
            rif.cdb1_value_in = 64'h1000 + 64'(i - 1);
         end
         @(negedge clock);
         if (i < 40) begin
            total++;
            if (rif.inst1_grant_out !== 1'b1 || rif.inst1_tag_out !== tag) begin
               bad++;
               $display("FAIL wrap_tag i=%0d got=%b/%0d exp=1/%0d", i, rif.inst1_grant_out, rif.inst1_tag_out, tag);
            end
         end
         prev_tag = tag;
         if (i < 40) tag = tag + IDX_W'(1);
         step();
      end
      clear_inputs();
      @(negedge clock);
      total++;
      if (exp_q.size() != 0 || rif.rob_empty !== 1'b1) begin
         bad++;
         $display("FAIL wrap_drain got=%0d/%b exp=0/1", exp_q.size(), rif.rob_empty);
      end
   endtask

   task automatic test_bypass();
      do_reset();
      rif.inst1_valid_in = 1'b1;
      rif.inst2_valid_in = 1'b1;
      repeat (3) step();
      clear_inputs();
      rif.cdb1_valid_in = 1'b1;
      rif.cdb1_tag_in   = 5'd5;
      rif.cdb1_value_in = 64'hAB;
      rif.rd_tag_in[0 +: IDX_W] = 5'd5;
      @(negedge clock);
      total++;
`ifdef ROB_CDB_BYPASS_EN
      if (rif.rd_ready_out[0] !== 1'b1 || rif.rd_value_out[0 +: DATA_W] !== 64'hAB) begin
         bad++;
         $display("FAIL bypass_same_cycle got=%b/%0h exp=1/ab", rif.rd_ready_out[0], rif.rd_value_out[0 +: DATA_W]);
      end
`else
      if (rif.rd_ready_out[0] !== 1'b0 || rif.rd_value_out[0 +: DATA_W] !== '0) begin
         bad++;
         $display("FAIL nobypass_same_cycle got=%b/%0h exp=0/0", rif.rd_ready_out[0], rif.rd_value_out[0 +: DATA_W]);
      end
`endif
      step();
      clear_inputs();
      rif.cdb1_valid_in = 1'b1;
      rif.cdb1_tag_in   = 5'd4;
      rif.cdb1_value_in = 64'h1;
      rif.cdb2_valid_in = 1'b1;
      rif.cdb2_tag_in   = 5'd4;
      rif.cdb2_value_in = 64'h2;
      rif.rd_tag_in[1*IDX_W +: IDX_W] = 5'd4;
      @(negedge clock);
      total++;
      if (rif.rd_ready_out[0] !== 1'b1 || rif.rd_value_out[0 +: DATA_W] !== 64'hAB) begin
         bad++;
         $display("FAIL read_next_cycle got=%b/%0h exp=1/ab", rif.rd_ready_out[0], rif.rd_value_out[0 +: DATA_W]);
      end
      total++;
`ifdef ROB_CDB_BYPASS_EN
      if (rif.rd_ready_out[1] !== 1'b1 || rif.rd_value_out[1*DATA_W +: DATA_W] !== 64'h1) begin
         bad++;
         $display("FAIL bypass_cdb1_prio got=%b/%0h exp=1/1", rif.rd_ready_out[1], rif.rd_value_out[1*DATA_W +: DATA_W]);
      end
`else
      if (rif.rd_ready_out[1] !== 1'b0) begin
         bad++;
         $display("FAIL nobypass_tag4 got=%b exp=0", rif.rd_ready_out[1]);
      end
`endif
      step();
      clear_inputs();
      rif.cdb1_valid_in = 1'b1;
      rif.cdb1_tag_in   = 5'd5;
      rif.cdb1_value_in = 64'hCD;
      rif.cdb2_valid_in = 1'b1;
      rif.cdb2_tag_in   = 5'd10;
      rif.cdb2_value_in = 64'hEE;
      rif.rd_tag_in[2*IDX_W +: IDX_W] = 5'd10;
      @(negedge clock);
      total++;
      if (rif.rd_ready_out[1] !== 1'b1 || rif.rd_value_out[1*DATA_W +: DATA_W] !== 64'h1) begin
         bad++;
         $display("FAIL same_tag_cdb1_wins got=%b/%0h exp=1/1", rif.rd_ready_out[1], rif.rd_value_out[1*DATA_W +: DATA_W]);
      end
      total++;
      if (rif.rd_value_out[0 +: DATA_W] !== 64'hAB || rif.rd_ready_out[2] !== 1'b0) begin
         bad++;
         $display("FAIL cdb_ignored_now got=%0h/%b exp=ab/0", rif.rd_value_out[0 +: DATA_W], rif.rd_ready_out[2]);
      end
      step();
      clear_inputs();
      @(negedge clock);
      total++;
      if (rif.rd_value_out[0 +: DATA_W] !== 64'hAB || rif.rd_ready_out[2] !== 1'b0 || rif.ret1_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL cdb_ignored_after got=%0h/%b/%b exp=ab/0/0", rif.rd_value_out[0 +: DATA_W],
                  rif.rd_ready_out[2], rif.ret1_valid_out);
      end
   endtask

   initial begin
      clear_inputs();
      rif.rd_tag_in = '0;
      test_reset();
      test_fill();
      test_lone_inst2();
      test_ooo_complete();
      test_mispredict();
      test_wrap();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
